// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage in front of the single-cycle datapath. It holds the fetch PC and
// sends word reads to an in-order instruction memory. Returned words are
// stored with their PCs in a small FIFO, and the FIFO head goes to the
// datapath over a valid/ready handshake. A redirect from the datapath
// (taken branch or jump) flushes the FIFO. Responses that are still in
// flight at that point are counted and discarded when they return.
//
// Ports
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   imem_req_*        request channel to instruction memory (valid/ready, addr)
//   imem_resp_*       in-order response channel (valid, data), no backpressure
//   inst_*            FIFO head to the datapath (valid, data, pc, ready)
//   redirect_*        one-cycle branch/jump redirect with new target PC
//   flushing          high while stale responses are being discarded
//
// Parameters
//   RESET_PC          fetch address after reset, word aligned
//   DEPTH             FIFO entries and maximum outstanding requests (2..8, pow2)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        flushing
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {
      RUN,
      DRAIN
   } state_t;

   state_t        state;
   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] inflight;
   logic [CW-1:0] drop;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   fifo_data [DEPTH];
   logic [31:0]   fifo_pc   [DEPTH];

   logic [CW:0]   occupancy;
   logic          credit;
   logic          accept;
   logic          push;
   logic          pop;
   logic          discard;
   logic [CW-1:0] inflight_next;
   logic [CW-1:0] count_next;
   logic [31:0]   redirect_target;

   // Buffered words and outstanding requests share one budget of DEPTH. A
   // response therefore always has a free FIFO slot, so the response channel
   // never needs backpressure.
   always_comb begin
      occupancy       = {1'b0, count} + {1'b0, inflight};
      credit          = occupancy < {1'b0, DEPTH_C};
      imem_req_valid  = !reset && !redirect_valid && credit;
      imem_req_addr   = fetch_pc;
      accept          = imem_req_valid && imem_req_ready;
      discard         = imem_resp_valid && ((drop != '0) || redirect_valid);
      push            = imem_resp_valid && (drop == '0) && !redirect_valid;
      pop             = (count != '0) && inst_ready && !redirect_valid;
      redirect_target = redirect_pc & 32'hFFFF_FFFC;
   end

   // Net change in the counters when an accept, a response and a pop all
   // happen in the same cycle.
   always_comb begin
      inflight_next = inflight;
      if (accept) begin
         inflight_next = inflight_next + CW'(1);
      end
      if (imem_resp_valid) begin
         inflight_next = inflight_next - CW'(1);
      end
      count_next = count;
      if (push) begin
         count_next = count_next + CW'(1);
      end
      if (pop) begin
         count_next = count_next - CW'(1);
      end
   end

   // Head of the FIFO is presented directly from storage. Data and PC read
   // as zero when the FIFO is empty so stale entries never reach the datapath.
   always_comb begin
      inst_valid = (count != '0);
      inst_data  = inst_valid ? fifo_data[rd_ptr] : 32'h0;
      inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : 32'h0;
      flushing   = (state == DRAIN);
   end

   // Control state and the RUN/DRAIN FSM. A redirect overrides everything.
   // Every request outstanding after this cycle's response is stale, so drop
   // is loaded with that count. resp_pc follows the target because the next
   // response that is kept belongs to the first request issued after the
   // redirect.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         count    <= '0;
         inflight <= '0;
         drop     <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_target;
         resp_pc  <= redirect_target;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         inflight <= inflight_next;
         drop     <= inflight_next;
         state    <= (inflight_next != '0) ? DRAIN : RUN;
      end else begin
         inflight <= inflight_next;
         count    <= count_next;
         if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (push) begin
            resp_pc <= resp_pc + 32'd4;
            wr_ptr  <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (discard) begin
            drop <= drop - CW'(1);
            if (drop == CW'(1)) begin
               state <= RUN;
            end
         end
      end
   end

   // FIFO storage. Writes happen only for responses that are kept. A redirect
   // resets the pointers, so no storage clear is needed there.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data[i] <= 32'h0;
            fifo_pc[i]   <= 32'h0;
         end
      end else if (push) begin
         fifo_data[wr_ptr] <= imem_resp_data;
         fifo_pc[wr_ptr]   <= resp_pc;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Drives instr_fetch_unit against an in-order memory model with configurable
// latency. Every accepted request pushes its expected {pc, word} onto a
// scoreboard queue. Every instruction handed to the datapath pops the queue
// and is compared. A redirect empties the queue, because everything fetched
// before it is stale.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;

   logic        clock;
   logic        reset;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flushing;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } inst_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc;
   int          mem_lat;
   logic        req_rdy;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];
   inst_t       exp_q     [$];
   logic [31:0] exp_fetch;

   logic        obs_reqv;
   logic        obs_acc;
   logic [31:0] obs_addr;
   logic        obs_ivalid;
   logic        obs_flush;
   logic        obs_pop;
   logic [31:0] obs_pop_pc;

   instr_fetch_unit #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_data       (inst_data),
      .inst_pc         (inst_pc),
      .inst_ready      (inst_ready),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .flushing        (flushing)
   );

   // Free-running clock, period 10
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Absolute time limit so a stuck run still terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Memory contents are a fixed scramble of the address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   // One clock cycle, entered and left at a falling edge. This task drives
   // the inputs, lets the logic settle, observes and scores the outputs, then
   // waits out the rising edge.
   task automatic run_cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
      inst_t e;
      inst_ready     = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      imem_req_ready = req_rdy;
      if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(pend_addr[0]);
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'h0;
      end
      #1;
      obs_reqv   = imem_req_valid;
      obs_acc    = imem_req_valid && imem_req_ready;
      obs_addr   = imem_req_addr;
      obs_ivalid = inst_valid;
      obs_flush  = flushing;
      obs_pop    = 1'b0;
      if (redir) begin
         checks++;
         if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL req_during_redirect: got %b expected 0", imem_req_valid);
         end
      end
      if (obs_acc) begin
         checks++;
         if (imem_req_addr !== exp_fetch) begin
            errors++;
            $display("[TB] FAIL req_addr: got %h expected %h", imem_req_addr, exp_fetch);
         end
         pend_addr.push_back(imem_req_addr);
         pend_due.push_back(cyc + mem_lat);
         exp_q.push_back('{pc: exp_fetch, data: mem_word(exp_fetch)});
         exp_fetch = exp_fetch + 32'd4;
      end
      if (inst_valid === 1'b1 && rdy && !redir) begin
         obs_pop    = 1'b1;
         obs_pop_pc = inst_pc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_inst: got pc %h data %h expected none", inst_pc, inst_data);
         end else begin
            e = exp_q.pop_front();
            if (inst_pc !== e.pc || inst_data !== e.data) begin
               errors++;
               $display("[TB] FAIL inst_stream: got pc %h data %h expected pc %h data %h",
                        inst_pc, inst_data, e.pc, e.data);
            end
         end
      end
      if (inst_valid !== 1'b1) begin
         checks++;
         if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL empty_head: got valid %b pc %h data %h expected 0 0 0",
                     inst_valid, inst_pc, inst_data);
         end
      end
      if (redir) begin
         exp_q.delete();
         exp_fetch = rpc & 32'hFFFF_FFFC;
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
   endtask

   // Stop issuing, consume everything outstanding, then idle a few cycles so
   // any duplicated instruction shows up as unexpected.
   task automatic drain();
      int n = 0;
      req_rdy = 1'b0;
      while ((exp_q.size() != 0 || pend_due.size() != 0) && n < 60) begin
         run_cycle(1'b1, 1'b0, 32'h0);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || pend_due.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout: got %0d queued %0d pending expected 0 0",
                  exp_q.size(), pend_due.size());
      end
      repeat (3) run_cycle(1'b1, 1'b0, 32'h0);
   endtask

   // Wait for the next delivered instruction and compare its PC
   task automatic expect_next_pc(input logic [31:0] pc);
      int n = 0;
      req_rdy = 1'b1;
      obs_pop = 1'b0;
      while (!obs_pop && n < 20) begin
         run_cycle(1'b1, 1'b0, 32'h0);
         n++;
      end
      checks++;
      if (!obs_pop || obs_pop_pc !== pc) begin
         errors++;
         $display("[TB] FAIL first_after_redirect: got pop %b pc %h expected pc %h", obs_pop, obs_pop_pc, pc);
      end
   endtask

   task automatic applyStimulus_idle();
      inst_ready      = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'h0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      applyStimulus_idle();
      req_rdy   = 1'b1;
      mem_lat   = 1;
      exp_fetch = RESET_PC;
      #3;
      checks += 4;
      if (imem_req_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid);
      end
      if (imem_req_addr !== RESET_PC) begin
         errors++;
         $display("[TB] FAIL reset_req_addr: got %h expected %h", imem_req_addr, RESET_PC);
      end
      if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_head: got %b %h %h expected 0 0 0", inst_valid, inst_data, inst_pc);
      end
      if (flushing !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flushing: got %b expected 0", flushing);
      end
      @(negedge clock);
      reset = 1'b0;
      cyc   = 1;
   endtask

   // First fetch at RESET_PC, address wrap on the second fetch, then one
   // instruction per cycle from cycle 3 onward
   task automatic test_stream();
      int c;
      int first = 0;
      int gaps  = 0;
      mem_lat = 1;
      req_rdy = 1'b1;
      for (int i = 0; i < 12; i++) begin
         c = cyc;
         run_cycle(1'b1, 1'b0, 32'h0);
         if (c == 1) begin
            checks++;
            if (!obs_acc || obs_addr !== RESET_PC) begin
               errors++;
               $display("[TB] FAIL first_req: got acc %b addr %h expected 1 %h", obs_acc, obs_addr, RESET_PC);
            end
         end
         if (c == 2) begin
            checks++;
            if (!obs_acc || obs_addr !== 32'h0) begin
               errors++;
               $display("[TB] FAIL wrap_req: got acc %b addr %h expected 1 00000000", obs_acc, obs_addr);
            end
         end
         if (obs_ivalid && first == 0) first = c;
         if (c >= 3 && !obs_ivalid) gaps++;
      end
      checks += 2;
      if (first != 3) begin
         errors++;
         $display("[TB] FAIL first_valid_cycle: got %0d expected 3", first);
      end
      if (gaps != 0) begin
         errors++;
         $display("[TB] FAIL throughput_gaps: got %0d expected 0", gaps);
      end
      drain();
   endtask

   task automatic test_backpressure();
      int acc = 0;
      mem_lat = 1;
      req_rdy = 1'b1;
      repeat (10) begin
         run_cycle(1'b0, 1'b0, 32'h0);
         if (obs_acc) acc++;
      end
      checks += 2;
      if (acc != DEPTH) begin
         errors++;
         $display("[TB] FAIL stall_accepts: got %0d expected %0d", acc, DEPTH);
      end
      if (obs_reqv !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_req_valid: got %b expected 0", obs_reqv);
      end
      run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (!obs_pop || obs_reqv !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pop_cycle: got pop %b req_valid %b expected 1 0", obs_pop, obs_reqv);
      end
      run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_reqv !== 1'b1) begin
         errors++;
         $display("[TB] FAIL credit_return: got %b expected 1", obs_reqv);
      end
      drain();
   endtask

   // Two requests in flight with latency 3, redirect to an unaligned target
   task automatic test_redirect();
      mem_lat = 3;
      req_rdy = 1'b1;
      run_cycle(1'b1, 1'b0, 32'h0);
      run_cycle(1'b1, 1'b0, 32'h0);
      req_rdy = 1'b0;
      run_cycle(1'b1, 1'b1, 32'h0000_1003);
      req_rdy = 1'b1;
      run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_flush !== 1'b1 || obs_ivalid !== 1'b0 || !obs_acc || obs_addr !== 32'h0000_1000) begin
         errors++;
         $display("[TB] FAIL redirect_r1: got flush %b valid %b acc %b addr %h expected 1 0 1 00001000",
                  obs_flush, obs_ivalid, obs_acc, obs_addr);
      end
      run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_flush !== 1'b1) begin
         errors++;
         $display("[TB] FAIL redirect_r2_flush: got %b expected 1", obs_flush);
      end
      run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_flush !== 1'b0) begin
         errors++;
         $display("[TB] FAIL redirect_r3_flush: got %b expected 0", obs_flush);
      end
      expect_next_pc(32'h0000_1000);
      drain();
   endtask

   // Redirect in the same cycle as a response and a ready head. One request
   // is left in flight after that cycle.
   task automatic test_coincident();
      mem_lat = 2;
      req_rdy = 1'b1;
      repeat (3) run_cycle(1'b0, 1'b0, 32'h0);
      req_rdy = 1'b0;
      run_cycle(1'b1, 1'b1, 32'h0000_2000);
      checks++;
      if (obs_ivalid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL coincident_head: got %b expected 1", obs_ivalid);
      end
      req_rdy = 1'b1;
      run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_ivalid !== 1'b0 || obs_flush !== 1'b1) begin
         errors++;
         $display("[TB] FAIL coincident_next: got valid %b flush %b expected 0 1", obs_ivalid, obs_flush);
      end
      run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (obs_flush !== 1'b0) begin
         errors++;
         $display("[TB] FAIL coincident_drop: got flush %b expected 0", obs_flush);
      end
      expect_next_pc(32'h0000_2000);
      drain();
   endtask

   task automatic test_async_reset();
      mem_lat = 1;
      req_rdy = 1'b1;
      repeat (6) run_cycle(1'b0, 1'b0, 32'h0);
      checks++;
      if (obs_ivalid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL prereset_valid: got %b expected 1", obs_ivalid);
      end
      #2;
      reset = 1'b1;
      #1;
      checks += 3;
      if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
         errors++;
         $display("[TB] FAIL async_reset_req: got %b %h expected 0 %h", imem_req_valid, imem_req_addr, RESET_PC);
      end
      if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
         errors++;
         $display("[TB] FAIL async_reset_head: got %b %h %h expected 0 0 0", inst_valid, inst_data, inst_pc);
      end
      if (flushing !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset_flush: got %b expected 0", flushing);
      end
      applyStimulus_idle();
      pend_addr.delete();
      pend_due.delete();
      exp_q.delete();
      exp_fetch = RESET_PC;
      @(negedge clock);
      reset = 1'b0;
      cyc   = 1;
      req_rdy = 1'b1;
      run_cycle(1'b1, 1'b0, 32'h0);
      checks++;
      if (!obs_acc || obs_addr !== RESET_PC) begin
         errors++;
         $display("[TB] FAIL restart_req: got acc %b addr %h expected 1 %h", obs_acc, obs_addr, RESET_PC);
      end
      repeat (6) run_cycle(1'b1, 1'b0, 32'h0);
      drain();
   endtask

   initial begin
      $display("[TB] starting instr_fetch_unit bench");
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_coincident();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
